fp_divider_param: RTL

Parametrised IEEE-754-style floating-point divider, the successor to the fixed 32-bit `floating_divider`. It computes z = a / b for any exponent/mantissa width using an iterative radix-2 restoring divide, one quotient bit per cycle. It adds selectable rounding (RNE/RTZ) and IEEE exception flags. It sits on the arithmetic datapath behind the same per-operand strobe/acknowledge handshake as the existing FP units.

---
 rtl/fp_divider_param_if.sv | 30 +++
 rtl/fp_divider_param.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fp_divider_param_if.sv
// Operand/result strobe-acknowledge bundle for fp_divider_param.
// Widths follow the same EXP_W/MAN_W parameters as the divider.
interface fp_divider_param_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic [W-1:0] input_a;
    logic         input_a_stb;
    logic         input_a_ack;
    logic [W-1:0] input_b;
    logic         input_b_stb;
    logic         input_b_ack;
    logic         round_mode;
    logic [W-1:0] output_z;
    logic         output_z_stb;
    logic         output_z_ack;
    logic [4:0]   output_flags;

    modport master (
        output input_a, input_a_stb, input_b, input_b_stb, round_mode, output_z_ack,
        input  input_a_ack, input_b_ack, output_z, output_z_stb, output_flags
    );

    modport slave (
        input  input_a, input_a_stb, input_b, input_b_stb, round_mode, output_z_ack,
        output input_a_ack, input_b_ack, output_z, output_z_stb, output_flags
    );
endinterface

// File: rtl/fp_divider_param.sv
// Parametrised floating-point divider: radix-2 restoring divide, one quotient bit
// per cycle, RNE/RTZ rounding, subnormals flushed to zero, IEEE exception flags.
module fp_divider_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic              clk,
    input  logic              rst,
    fp_divider_param_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int QW = MAN_W + 3;
    localparam int RW = MAN_W + 2;
    localparam int CW = $clog2(QW + 1);
    localparam logic signed [EW-1:0] BIAS  = EW'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [EW-1:0] EMAX  = EW'(2 ** EXP_W - 1);
    localparam logic signed [EW-1:0] EZERO = '0;

    typedef enum logic [3:0] {
        GET_A, GET_B, UNPACK, SPECIAL, DIVIDE, NORMALISE, ROUND, PACK, PUT_Z
    } state_t;

    state_t r_state, w_next;

    logic [W-1:0]          r_a, r_b, r_z;
    logic [4:0]            r_flags;
    logic                  r_rm, r_sz;
    logic [EXP_W-1:0]      r_ea, r_eb;
    logic [MAN_W:0]        r_ma, r_mb, r_m;
    logic signed [EW-1:0]  r_ez;
    logic [QW-1:0]         r_q;
    logic [RW-1:0]         r_rem;
    logic [CW-1:0]         r_cnt;
    logic                  r_g, r_r, r_s, r_nx;

    logic                  w_a_max, w_b_max, w_a_zero, w_b_zero;
    logic                  w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_special;
    logic [W-1:0]          w_spec_z;
    logic [4:0]            w_spec_flags;
    logic [RW:0]           w_diff;
    logic                  w_ge;
    logic [RW-1:0]         w_rem_nx;
    logic                  w_inc;
    logic [MAN_W+1:0]      w_sum;

    assign bus.input_a_ack  = (r_state == GET_A);
    assign bus.input_b_ack  = (r_state == GET_B);
    assign bus.output_z_stb = (r_state == PUT_Z);
    assign bus.output_z     = r_z;
    assign bus.output_flags = r_flags;

    // Operand classification; r_ma/r_mb keep the raw fraction when the exponent is all ones.
    assign w_a_max   = &r_ea;
    assign w_b_max   = &r_eb;
    assign w_a_zero  = (r_ea == '0);
    assign w_b_zero  = (r_eb == '0);
    assign w_a_nan   = w_a_max && (|r_ma[MAN_W-1:0]);
    assign w_b_nan   = w_b_max && (|r_mb[MAN_W-1:0]);
    assign w_a_inf   = w_a_max && !(|r_ma[MAN_W-1:0]);
    assign w_b_inf   = w_b_max && !(|r_mb[MAN_W-1:0]);
    assign w_special = w_a_max || w_b_max || w_a_zero || w_b_zero;

    always_comb begin
        w_spec_z     = {r_sz, {(W-1){1'b0}}};
        w_spec_flags = '0;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_z     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            w_spec_flags = 5'b10000;
        end else if (w_a_inf) begin
            w_spec_z = {r_sz, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_b_zero) begin
            w_spec_z     = {r_sz, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_spec_flags = 5'b01000;
        end
    end

    assign w_diff   = {1'b0, r_rem} - {2'b00, r_mb};
    assign w_ge     = !w_diff[RW];
    assign w_rem_nx = w_ge ? w_diff[RW-1:0] : r_rem;
    assign w_inc    = !r_rm && r_g && (r_r || r_s || r_m[0]);
    assign w_sum    = {1'b0, r_m} + (MAN_W+2)'(w_inc);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            GET_A:     if (bus.input_a_stb) w_next = GET_B;
            GET_B:     if (bus.input_b_stb) w_next = UNPACK;
            UNPACK:    w_next = SPECIAL;
            SPECIAL:   w_next = w_special ? PUT_Z : DIVIDE;
            DIVIDE:    if (r_cnt == CW'(QW - 1)) w_next = NORMALISE;
            NORMALISE: w_next = ROUND;
            ROUND:     w_next = PACK;
            PACK:      w_next = PUT_Z;
            PUT_Z:     if (bus.output_z_ack) w_next = GET_A;
            default:   w_next = GET_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= GET_A;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a <= '0; r_b <= '0; r_z <= '0; r_flags <= '0;
            r_rm <= 1'b0; r_sz <= 1'b0;
            r_ea <= '0; r_eb <= '0; r_ma <= '0; r_mb <= '0; r_m <= '0;
            r_ez <= '0; r_q <= '0; r_rem <= '0; r_cnt <= '0;
            r_g <= 1'b0; r_r <= 1'b0; r_s <= 1'b0; r_nx <= 1'b0;
        end else begin
            unique case (r_state)
                GET_A: if (bus.input_a_stb) r_a <= bus.input_a;
                GET_B: if (bus.input_b_stb) begin
                    r_b  <= bus.input_b;
                    r_rm <= bus.round_mode;
                end
                UNPACK: begin
                    r_sz <= r_a[W-1] ^ r_b[W-1];
                    r_ea <= r_a[W-2:MAN_W];
                    r_eb <= r_b[W-2:MAN_W];
                    r_ma <= (r_a[W-2:MAN_W] == '0) ? '0 : {1'b1, r_a[MAN_W-1:0]};
                    r_mb <= (r_b[W-2:MAN_W] == '0) ? '0 : {1'b1, r_b[MAN_W-1:0]};
                end
                SPECIAL: begin
                    if (w_special) begin
                        r_z     <= w_spec_z;
                        r_flags <= w_spec_flags;
                    end else begin
                        r_ez  <= $signed({2'b00, r_ea}) - $signed({2'b00, r_eb}) + BIAS;
                        r_rem <= {1'b0, r_ma};
                        r_q   <= '0;
                        r_cnt <= '0;
                    end
                end
                DIVIDE: begin
                    r_q   <= {r_q[QW-2:0], w_ge};
                    r_rem <= {w_rem_nx[RW-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                end
                NORMALISE: begin
                    r_s <= |r_rem;
                    if (r_q[QW-1]) begin
                        r_m <= r_q[QW-1:2];
                        r_g <= r_q[1];
                        r_r <= r_q[0];
                    end else begin
                        r_m  <= r_q[QW-2:1];
                        r_g  <= r_q[0];
                        r_r  <= 1'b0;
                        r_ez <= r_ez - 1'b1;
                    end
                end
                ROUND: begin
                    r_nx <= r_g || r_r || r_s;
                    if (w_sum[MAN_W+1]) begin
                        r_m  <= {1'b1, {MAN_W{1'b0}}};
                        r_ez <= r_ez + 1'b1;
                    end else begin
                        r_m <= w_sum[MAN_W:0];
                    end
                end
                PACK: begin
                    if (r_ez >= EMAX) begin
                        r_flags <= 5'b00101;
                        r_z <= r_rm ? {r_sz, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                                    : {r_sz, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    end else if (r_ez <= EZERO) begin
                        r_flags <= 5'b00011;
                        r_z     <= {r_sz, {(W-1){1'b0}}};
                    end else begin
                        r_flags <= {4'b0000, r_nx};
                        r_z     <= {r_sz, r_ez[EXP_W-1:0], r_m[MAN_W-1:0]};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
